// File: rtl/keypad_cursor_input.sv
// Five-button debounced cursor over a 4x6 virtual keypad; presents the key code
// under the cursor on val and pulses enter_button on each center press.
module keypad_cursor_input #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [4:0] val,
  output logic       enter_button,
  output logic [2:0] cursor_row,
  output logic [1:0] cursor_col
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 center
  logic [4:0] btn_raw;
  logic [4:0] sync_p0, sync_p1;
  logic [4:0] lvl_p2, lvl_p3;
  logic [4:0] press;
  logic [3:0] pend, pend_n, mv_src, mv_sel, apply;
  logic [2:0] row_n;
  logic [1:0] col_n;

  assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  function automatic logic [2:0] row_step(input logic [2:0] r, input logic dn);
    if (dn) return (r == 3'd5) ? 3'd0 : r + 3'd1;
    return (r == 3'd0) ? 3'd5 : r - 3'd1;
  endfunction

  function automatic logic [1:0] col_step(input logic [1:0] c, input logic rt);
    if (rt) return (c == 2'd3) ? 2'd0 : c + 2'd1;
    return (c == 2'd0) ? 2'd3 : c - 2'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-channel debounce; any sample matching lvl restarts the count
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_p1[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync_p1[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign lvl_p2[i] = lvl;
  end

  // Stage p3: previous level for rising-edge press strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_p3 <= '0;
    else      lvl_p3 <= lvl_p2;
  end

  assign press = lvl_p2 & ~lvl_p3;

  // A move coinciding with a center press is held one cycle so the entered code is the old one
  always_comb begin
    mv_src = (pend != 4'b0) ? pend : press[3:0];
    mv_sel = 4'b0;
    if      (mv_src[0]) mv_sel = 4'b0001;
    else if (mv_src[1]) mv_sel = 4'b0010;
    else if (mv_src[2]) mv_sel = 4'b0100;
    else if (mv_src[3]) mv_sel = 4'b1000;
    pend_n = press[4] ? mv_sel : 4'b0;
    apply  = press[4] ? 4'b0 : mv_sel;
    row_n  = cursor_row;
    col_n  = cursor_col;
    if (apply[0] || apply[1]) row_n = row_step(cursor_row, apply[1]);
    if (apply[2] || apply[3]) col_n = col_step(cursor_col, apply[3]);
  end

  // Stage p4: registered cursor, key code and enter pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_row   <= 3'd0;
      cursor_col   <= 2'd0;
      val          <= 5'd0;
      enter_button <= 1'b0;
      pend         <= 4'b0;
    end else begin
      cursor_row   <= row_n;
      cursor_col   <= col_n;
      val          <= {row_n, col_n};
      enter_button <= press[4];
      pend         <= pend_n;
    end
  end

endmodule

// File: tb/tb_keypad_cursor_input.sv
// Directed bench for keypad_cursor_input with DEBOUNCE_CYCLES = 4.
module tb_keypad_cursor_input;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_center = 1'b0;
  logic [4:0] val;
  logic       enter_button;
  logic [2:0] cursor_row;
  logic [1:0] cursor_col;

  int n_cmp  = 0;
  int n_fail = 0;
  int enter_cnt = 0;
  int enter_val = 0;
  int consec = 0;
  logic enter_prev = 1'b0;

  keypad_cursor_input #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .val(val), .enter_button(enter_button),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enter_button) begin
      enter_cnt++;
      enter_val = int'(val);
      if (enter_prev) consec++;
    end
    enter_prev = enter_button;
  end

  typedef struct {
    logic [4:0] btn;   // {center, right, left, down, up}
    int row;
    int col;
    int v;
    int enters;
    int ev;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_center, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic check_pos(input string tag, input int r, input int c, input int v);
    check({tag, "_row"}, int'(cursor_row), r);
    check({tag, "_col"}, int'(cursor_col), c);
    check({tag, "_val"}, int'(val), v);
  endtask

  initial begin
    int e0;

    tbl[0]  = '{5'b00100, 1, 3, 'h07, 0, 0};
    tbl[1]  = '{5'b00001, 0, 3, 'h03, 0, 0};
    tbl[2]  = '{5'b00001, 5, 3, 'h17, 0, 0};
    tbl[3]  = '{5'b00010, 0, 3, 'h03, 0, 0};
    tbl[4]  = '{5'b01000, 0, 0, 'h00, 0, 0};
    tbl[5]  = '{5'b00100, 0, 3, 'h03, 0, 0};
    tbl[6]  = '{5'b00001, 5, 3, 'h17, 0, 0};
    tbl[7]  = '{5'b00010, 0, 3, 'h03, 0, 0};
    tbl[8]  = '{5'b00010, 1, 3, 'h07, 0, 0};
    tbl[9]  = '{5'b00010, 2, 3, 'h0B, 0, 0};
    tbl[10] = '{5'b00100, 2, 2, 'h0A, 0, 0};
    tbl[11] = '{5'b00101, 1, 2, 'h06, 0, 0};
    tbl[12] = '{5'b01010, 2, 2, 'h0A, 0, 0};
    tbl[13] = '{5'b01100, 2, 1, 'h09, 0, 0};
    tbl[14] = '{5'b00010, 3, 1, 'h0D, 0, 0};
    tbl[15] = '{5'b00010, 4, 1, 'h11, 0, 0};
    tbl[16] = '{5'b01000, 4, 2, 'h12, 0, 0};
    tbl[17] = '{5'b01000, 4, 3, 'h13, 0, 0};
    tbl[18] = '{5'b10000, 4, 3, 'h13, 1, 'h13};
    tbl[19] = '{5'b01111, 3, 3, 'h0F, 0, 0};
    tbl[20] = '{5'b11000, 3, 0, 'h0C, 1, 'h0F};

    // reset state
    cycles(3);
    check_pos("reset", 0, 0, 0);
    check("reset_enter", int'(enter_button), 0);
    rst = 1'b1;
    cycles(2);

    // single right press: move lands exactly 7 edges after assertion
    btn_right = 1'b1;
    cycles(DB + 2);
    check("right_early_col", int'(cursor_col), 0);
    cycles(1);
    check_pos("right_move", 0, 1, 1);
    cycles(3);
    btn_right = 1'b0;
    cycles(10);
    check_pos("right_single", 0, 1, 1);

    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(2);

    // bouncing down press rejected, then a clean hold accepted once
    btn_down = 1'b1; cycles(3);
    btn_down = 1'b0; cycles(1);
    btn_down = 1'b1; cycles(3);
    btn_down = 1'b0; cycles(10);
    check_pos("bounce", 0, 0, 0);
    btn_down = 1'b1; cycles(10);
    btn_down = 1'b0; cycles(10);
    check_pos("down_clean", 1, 0, 4);

    for (int i = 0; i < 21; i++) begin
      e0 = enter_cnt;
      set_btns(tbl[i].btn);
      cycles(10);
      set_btns(5'b0);
      cycles(10);
      check_pos($sformatf("vec%0d", i), tbl[i].row, tbl[i].col, tbl[i].v);
      check($sformatf("vec%0d_enters", i), enter_cnt - e0, tbl[i].enters);
      if (tbl[i].enters > 0)
        check($sformatf("vec%0d_enter_val", i), enter_val, tbl[i].ev);
    end

    // reset during a pending right press; held button debounces afresh after release
    btn_right = 1'b1;
    cycles(2);
    rst = 1'b0;
    #1;
    check_pos("midreset", 0, 0, 0);
    check("midreset_enter", int'(enter_button), 0);
    cycles(2);
    rst = 1'b1;
    cycles(DB + 2);
    check("postreset_early_col", int'(cursor_col), 0);
    cycles(1);
    check_pos("postreset_move", 0, 1, 1);
    cycles(5);
    btn_right = 1'b0;
    cycles(10);
    check_pos("postreset_single", 0, 1, 1);

    check("enter_consecutive", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
